// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM encoding and op normalisation for the sequential ALU.
// Optional multiplier is enabled by defining SEQ_ALU_MUL_EN.
package seq_alu_pkg;

    localparam int unsigned OP_W = 5;

    // Canonical codes; legacy "x" codes are normalised to op[3]=0 before decode
    localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB    = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND    = 5'b00001;
    localparam logic [OP_W-1:0] OP_OR     = 5'b00101;
    localparam logic [OP_W-1:0] OP_XOR    = 5'b00010;
    localparam logic [OP_W-1:0] OP_SHLH   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL    = 5'b00011;
    localparam logic [OP_W-1:0] OP_SRL    = 5'b00111;
    localparam logic [OP_W-1:0] OP_SRA    = 5'b01111;
    localparam logic [OP_W-1:0] OP_HAMM   = 5'b01011;
    localparam logic [OP_W-1:0] OP_MULLO  = 5'b10000;
    localparam logic [OP_W-1:0] OP_POPCNT = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legacy codes whose low two bits are not 11 ignore op[3]
    function automatic logic [OP_W-1:0] norm_op(input logic [OP_W-1:0] op);
        if (!op[4] && (op[1:0] != 2'b11)) begin
            return {2'b00, op[2:0]};
        end
        return op;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between the EX stage and seq_alu.
interface seq_alu_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/seq_alu_popk.sv
// Combinational population count of one K-bit slice, shared by HAMM and POPCNT.
module seq_alu_popk #(
    parameter  int unsigned K    = 4,
    localparam int unsigned PK_W = $clog2(K) + 1
) (
    input  logic [K-1:0]    i_bits,
    output logic [PK_W-1:0] o_cnt_c
);

    always_comb begin
        o_cnt_c = '0;
        for (int i = 0; i < K; i++) begin
            o_cnt_c = o_cnt_c + PK_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: 1-cycle legacy ops, K-bit/cycle HAMM/POPCNT and optional MULLO.
// MULLO and its shift-add datapath exist only when SEQ_ALU_MUL_EN is defined.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned K = 4
) (
    input logic      clock,
    input logic      resetn,
    seq_alu_if.slave bus
);

    localparam int unsigned N     = W / K;
    localparam int unsigned SH_W  = $clog2(W);
    localparam int unsigned PC_W  = SH_W + 1;
    localparam int unsigned PK_W  = $clog2(K) + 1;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_sh;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic [W-1:0]      r_result;
    logic              r_zero;
    logic              r_err;

    logic [OP_W-1:0]   w_op_n;
    logic [SH_W-1:0]   w_sh;
    logic [W-1:0]      w_fast_res;
    logic              w_fast_err;
    logic              w_iter;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic [PK_W-1:0]   w_pk;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [W-1:0]      w_iter_res;

`ifdef SEQ_ALU_MUL_EN
    logic [W-1:0]      r_mcand;
    logic [W-1:0]      r_macc;
    logic              r_is_mul;
    logic [W-1:0]      w_macc_nxt;
`endif

    assign w_op_n = norm_op(bus.op);
    assign w_sh   = bus.a[SH_W-1:0];

    // Decode of the presented op: 1-cycle result or iterative flag
    always_comb begin
        w_fast_res = '0;
        w_fast_err = 1'b0;
        w_iter     = 1'b0;
        case (w_op_n)
            OP_ADD:    w_fast_res = bus.a + bus.b;
            OP_SUB:    w_fast_res = bus.a - bus.b;
            OP_AND:    w_fast_res = bus.a & bus.b;
            OP_OR:     w_fast_res = bus.a | bus.b;
            OP_XOR:    w_fast_res = bus.a ^ bus.b;
            OP_SHLH:   w_fast_res = bus.a << (W / 2);
            OP_SHL:    w_fast_res = bus.b << w_sh;
            OP_SRL:    w_fast_res = bus.b >> w_sh;
            OP_SRA:    w_fast_res = W'($signed(bus.b) >>> w_sh);
            OP_HAMM:   w_iter     = 1'b1;
            OP_POPCNT: w_iter     = 1'b1;
`ifdef SEQ_ALU_MUL_EN
            OP_MULLO:  w_iter     = 1'b1;
`endif
            default:   w_fast_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == ST_IDLE);
        w_out_valid = (r_state == ST_DONE);
        w_accept    = w_in_ready & bus.in_valid;
        w_step      = (r_state == ST_BUSY);
        w_last      = w_step && (r_cnt == CNT_W'(N - 1));
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;

    seq_alu_popk #(.K(K)) u_popk (
        .i_bits  (r_sh[K-1:0]),
        .o_cnt_c (w_pk)
    );

    assign w_pc_nxt = r_pc + PC_W'(w_pk);

`ifdef SEQ_ALU_MUL_EN
    // Shift-add: one K-bit digit of the multiplier per BUSY cycle
    always_comb begin
        w_macc_nxt = r_macc;
        for (int j = 0; j < K; j++) begin
            if (r_sh[j]) begin
                w_macc_nxt = w_macc_nxt + (r_mcand << j);
            end
        end
    end

    assign w_iter_res = r_is_mul ? w_macc_nxt : W'(w_pc_nxt);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mcand  <= '0;
            r_macc   <= '0;
            r_is_mul <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= bus.a;
            r_macc   <= '0;
            r_is_mul <= (w_op_n == OP_MULLO);
        end else if (w_step) begin
            r_mcand  <= r_mcand << K;
            r_macc   <= w_macc_nxt;
        end
    end
`else
    assign w_iter_res = W'(w_pc_nxt);
`endif

    // Operand shift register, popcount accumulator, step counter and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sh     <= '0;
            r_pc     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_pc  <= '0;
            r_cnt <= '0;
            if (w_op_n == OP_HAMM) begin
                r_sh <= bus.a ^ bus.b;
            end else if (w_op_n == OP_POPCNT) begin
                r_sh <= bus.a;
            end else begin
                r_sh <= bus.b;
            end
            if (!w_iter) begin
                r_result <= w_fast_res;
                r_zero   <= (w_fast_res == '0);
                r_err    <= w_fast_err;
            end
        end else if (w_step) begin
            r_sh  <= r_sh >> K;
            r_pc  <= w_pc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_iter_res;
                r_zero   <= (w_iter_res == '0);
                r_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 32;
    localparam int unsigned K = 4;
    localparam int unsigned N = W / K;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu_if #(.W(W)) bus ();

    seq_alu #(.W(W), .K(K)) u_dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: result, err flag and latency (cycles from accept edge to out_valid)
    function automatic void model(input logic [4:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic e, output int lat);
        int sh;
        sh  = int'(a % W);
        r   = '0;
        e   = 1'b0;
        lat = 1;
        if (!op[4]) begin
            casez (op[3:0])
                4'b?000: r = a + b;
                4'b?100: r = a - b;
                4'b?001: r = a & b;
                4'b?101: r = a | b;
                4'b?010: r = a ^ b;
                4'b?110: r = a << (W / 2);
                4'b0011: r = b << sh;
                4'b0111: r = b >> sh;
                4'b1111: r = W'($signed(b) >>> sh);
                4'b1011: begin r = W'($countones(a ^ b)); lat = N + 1; end
                default: r = '0;
            endcase
        end else if (op == 5'b10001) begin
            r   = W'($countones(a));
            lat = N + 1;
        end else if (op == 5'b10000) begin
`ifdef SEQ_ALU_MUL_EN
            r   = a * b;
            lat = N + 1;
`else
            e   = 1'b1;
`endif
        end else begin
            e = 1'b1;
        end
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_r;
        logic         exp_e;
        int           exp_lat;
        int           cyc;
        bit           busy_rdy;
        model(op, a, b, exp_r, exp_e, exp_lat);
        @(negedge clk);
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        cyc      = 1;
        busy_rdy = 1'b0;
        while (!bus.out_valid && cyc < 4 * N) begin
            busy_rdy |= bus.in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_ready", 64'(busy_rdy), 64'(0));
        check("result", 64'(bus.result), 64'(exp_r));
        check("zero", 64'(bus.zero), 64'(exp_r == '0));
        check("err", 64'(bus.err), 64'(exp_e));
        if (hold > 0) begin
            repeat (hold) begin
                bus.in_valid = 1'b1;
                bus.op       = 5'($urandom);
                bus.a        = $urandom;
                bus.b        = $urandom;
                @(posedge clk); #1;
            end
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_ready", 64'(bus.in_ready), 64'(0));
            check("hold_result", 64'(bus.result), 64'(exp_r));
            check("hold_err", 64'(bus.err), 64'(exp_e));
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_ready", 64'(bus.in_ready), 64'(1));
        check("post_valid", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_result"}, 64'(bus.result), 64'(0));
        check({tag, "_zero"}, 64'(bus.zero), 64'(1));
        check({tag, "_err"}, 64'(bus.err), 64'(0));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_vals("reset");

        run_op(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(5'b01111, 32'h0000_0024, 32'h8000_0000, 0);
        run_op(5'b01000, 32'h1234_5678, 32'h1111_1111, 0);
        run_op(5'b00110, 32'h0000_ABCD, 32'h0, 0);
        run_op(5'b01011, 32'h0F0F_0F0F, 32'h0, 0);
        run_op(5'b01011, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(5'b10001, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(5'b10001, 32'h0, 32'hFFFF_FFFF, 0);
        run_op(5'b10000, 32'h0001_0003, 32'h0000_0005, 0);
        run_op(5'b10111, 32'h5, 32'h6, 0);
        run_op(5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 10);
        run_op(5'b01011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 10);

        // Abort an in-flight HAMM in its third BUSY cycle
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 5'b01011;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_busy", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(5'b01011, 32'hDEAD_BEEF, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [4:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           hold;
            op   = 5'($urandom);
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '0;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(op, a, b, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
